// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: mode encodings and the two linear transforms
// used by the round function (L) and the key schedule (L').
package sm4_pkg;

    localparam logic MODE_L  = 1'b0;
    localparam logic MODE_LP = 1'b1;

    function automatic logic [31:0] rotl32(input logic [31:0] x,
                                           input logic [4:0]  n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] l_enc(input logic [31:0] b);
        return b ^ rotl32(b, 5'd2) ^ rotl32(b, 5'd10)
                 ^ rotl32(b, 5'd18) ^ rotl32(b, 5'd24);
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] b);
        return b ^ rotl32(b, 5'd13) ^ rotl32(b, 5'd23);
    endfunction

endpackage

// File: rtl/sm4_sbox.sv
// SM4 S-box: one combinational 8-bit lookup.
module sm4_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    localparam logic [0:255][7:0] SBOX = {
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/sm4_t_pipe.sv
// Two-stage SM4 T transform (tau then L or L') over LANES words per beat,
// with valid/ready flow control and full backpressure.
module sm4_t_pipe
    import sm4_pkg::*;
#(
    parameter int LANES = 1,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*LANES-1:0]   in_data,
    input  logic                  in_mode,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]      out_tag
);

    logic                s1_valid_q, s2_valid_q;
    logic [32*LANES-1:0] s1_data_q, s2_data_q;
    logic                s1_mode_q;
    logic [TAG_W-1:0]    s1_tag_q, s2_tag_q;
    logic [32*LANES-1:0] tau_d, l_d;
    logic                s1_en, s2_en;

    assign s2_en    = ~s2_valid_q | out_ready;
    assign s1_en    = ~s1_valid_q | s2_en;
    assign in_ready = s1_en;

    for (genvar g = 0; g < 4 * LANES; g++) begin : g_sbox
        sm4_sbox u_sbox (
            .byte_i (in_data[8*g +: 8]),
            .byte_o (tau_d[8*g +: 8])
        );
    end

    always_comb begin
        l_d = '0;
        for (int k = 0; k < LANES; k++) begin
            l_d[32*k +: 32] = (s1_mode_q == MODE_LP) ? l_key(s1_data_q[32*k +: 32])
                                                     : l_enc(s1_data_q[32*k +: 32]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= MODE_L;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_data_q <= tau_d;
                    s1_mode_q <= in_mode;
                    s1_tag_q  <= in_tag;
                end
            end
            // s1 data is only consumed when it holds a live beat
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= l_d;
                    s2_tag_q  <= s1_tag_q;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;

endmodule
